counter_sequencer: RTL

Command-driven controller that sequences an 8-bit up-counter datapath as a programmable timer. Accepts START/STOP/CLEAR commands over a valid/ready handshake. Applies a clock prescaler and runs the count in one-shot or periodic mode, producing terminal-count and done indications. Sits between the control logic and the counting datapath.

---
 rtl/counter_sequencer_if.sv | 37 +++
 rtl/counter_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer_if.sv
// Command channel for counter_sequencer.
// Ports (signals):
//   cmd_valid  command present (master -> slave)
//   cmd_ready  slave can accept a command this cycle (slave -> master)
//   cmd_op     00 NOP, 01 START, 10 STOP, 11 CLEAR
//   cmd_limit  terminal count value, sampled on START from IDLE/RUN/DONE
//   cmd_mode   0 one-shot, 1 periodic, sampled with cmd_limit
//   cmd_psc    prescale divisor minus 1, sampled with cmd_limit
interface counter_sequencer_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PSC_WIDTH = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [WIDTH-1:0]     cmd_limit;
  logic                 cmd_mode;
  logic [PSC_WIDTH-1:0] cmd_psc;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_limit,
    output cmd_mode,
    output cmd_psc,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_limit,
    input  cmd_mode,
    input  cmd_psc,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sequencer.sv
// Programmable timer controller: sequences an up-counter through
// IDLE/LOAD/RUN/PAUSE/DONE under START/STOP/CLEAR commands, with a
// clock prescaler and one-shot or periodic operation.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous reset, active low
//   cmd       command channel (slave side of counter_sequencer_if)
//   count_o   current count
//   busy      high in LOAD and RUN
//   tc_pulse  registered one-cycle pulse per terminal tick
//   done      high while in DONE
module counter_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PSC_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  counter_sequencer_if.slave cmd,
  output logic [WIDTH-1:0] count_o,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StPause, StDone} state_e;

  localparam logic [1:0] OpStart = 2'b01;
  localparam logic [1:0] OpStop  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0]     limit_q, limit_d;
  logic                 mode_q, mode_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic                 tc_q, tc_d;

  logic accept, is_start, is_stop, is_clear, cmd_override;
  logic tick, terminal, cfg_load;

  // Command decode and tick generation
  always_comb begin
    accept       = cmd.cmd_valid && (state_q != StLoad);
    is_start     = accept && (cmd.cmd_op == OpStart);
    is_stop      = accept && (cmd.cmd_op == OpStop);
    is_clear     = accept && (cmd.cmd_op == OpClear);
    // NOP is accepted but never displaces a tick
    cmd_override = is_start || is_stop || is_clear;
    tick         = (state_q == StRun) && (psc_cnt_q == psc_q);
    terminal     = tick && (count_q == limit_q);
    // Config is only resampled on START from states that go through LOAD
    cfg_load     = is_start && ((state_q == StIdle) || (state_q == StRun) ||
                                (state_q == StDone));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (is_start) state_d = StLoad;
      end
      StLoad: begin
        state_d = StRun;
      end
      StRun: begin
        if (is_start) begin
          state_d = StLoad;
        end else if (is_stop) begin
          state_d = StPause;
        end else if (is_clear) begin
          state_d = StIdle;
        end else if (terminal && !mode_q) begin
          state_d = StDone;
        end
      end
      StPause: begin
        if (is_start) begin
          state_d = StRun;
        end else if (is_clear) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        if (is_start) begin
          state_d = StLoad;
        end else if (is_clear) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd.cmd_ready = (state_q != StLoad);
    busy          = (state_q == StLoad) || (state_q == StRun);
    done          = (state_q == StDone);
    count_o       = count_q;
    tc_pulse      = tc_q;
  end

  // Datapath next state
  always_comb begin
    count_d   = count_q;
    psc_cnt_d = psc_cnt_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    psc_d     = psc_q;
    tc_d      = 1'b0;

    if (cfg_load) begin
      limit_d   = cmd.cmd_limit;
      mode_d    = cmd.cmd_mode;
      psc_d     = cmd.cmd_psc;
      count_d   = '0;
      psc_cnt_d = '0;
    end

    if (is_clear) begin
      count_d = '0;
    end

    case (state_q)
      StLoad: begin
        count_d   = '0;
        psc_cnt_d = '0;
      end
      StRun: begin
        // STOP freezes both counters; START/CLEAR handled above
        if (!cmd_override) begin
          if (tick) begin
            psc_cnt_d = '0;
            if (terminal) begin
              tc_d = 1'b1;
              // One-shot holds at limit; periodic reloads
              if (mode_q) count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            psc_cnt_d = psc_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      psc_cnt_q <= '0;
      limit_q   <= '0;
      mode_q    <= 1'b0;
      psc_q     <= '0;
      tc_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      psc_cnt_q <= psc_cnt_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      psc_q     <= psc_d;
      tc_q      <= tc_d;
    end
  end

endmodule
